// File: rtl/aes_inv_sub_bytes_seq.sv
// aes_inv_sub_bytes_seq: sequential AES InvSubBytes, LANES bytes per cycle over valid/ready.
// Optional macro AES_INV_SBOX_REG_EN registers each lane's InvS output before the result write.
module aes_inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam int NG = 16 / LANES;
  localparam int W = 8 * LANES;
  localparam logic [4:0] LAST = 5'(NG - 1);
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [127:0] src, res;
  logic [4:0] grp;
  logic [3:0] sel;
  logic fin;
  logic [W-1:0] lane_in, lane_out;
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  assign sel = grp <= LAST ? grp[3:0] : 4'd0;
  assign lane_in = src[W*sel +: W];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_out[8*l +: 8] = INV_SBOX[lane_in[8*l +: 8]];
  end
  assign out_data = res;
`ifdef AES_INV_SBOX_REG_EN
  logic [W-1:0] pipe;
  logic pipe_v;
  logic [3:0] pipe_g;
  // one extra BUSY cycle drains the last group out of the pipeline stage
  assign fin = grp == LAST + 5'd1;
`else
  assign fin = grp == LAST;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      src <= '0;
      res <= '0;
      grp <= '0;
`ifdef AES_INV_SBOX_REG_EN
      pipe <= '0;
      pipe_v <= 1'b0;
      pipe_g <= '0;
`endif
    end else begin
`ifdef AES_INV_SBOX_REG_EN
      pipe <= lane_out;
      pipe_v <= state == BUSY && grp <= LAST;
      pipe_g <= sel;
      if (pipe_v) res[W*pipe_g +: W] <= pipe;
`endif
      case (state)
        IDLE: if (in_valid) begin
          src <= in_data;
          grp <= '0;
          in_ready <= 1'b0;
          state <= BUSY;
        end
        BUSY: begin
`ifndef AES_INV_SBOX_REG_EN
          res[W*sel +: W] <= lane_out;
`endif
          grp <= fin ? 5'd0 : grp + 5'd1;
          if (fin) begin
            state <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// tb_aes_inv_sub_bytes_seq: scoreboard bench for aes_inv_sub_bytes_seq (LANES=4 main unit plus a LANES sweep).
// Honours AES_INV_SBOX_REG_EN for the expected latency.
module tb_aes_inv_sub_bytes_seq;
  localparam int LANES = 4;
  localparam int NG = 16 / LANES;
`ifdef AES_INV_SBOX_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = NG + EXTRA;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [127:0] BASIC_IN = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] BASIC_EXP = 128'h0f0e0d0c0b0a09080706050403020100;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [127:0] in_data = '0, out_data;
  logic sw_valid = 1'b0;
  logic [127:0] sw_data = '0;
  logic sw_in_ready [4];
  logic sw_out_valid [4];
  logic [127:0] sw_out_data [4];
  int cyc = 0, checks = 0, errors = 0, last_acc = -1, mon_acc;
  logic ov_prev = 1'b0;
  logic [127:0] exp_q [$];
  int acc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_sub_bytes_seq #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    aes_inv_sub_bytes_seq #(.LANES(g < 2 ? 1 << g : 1 << (g + 1))) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[g]), .in_data(sw_data),
      .out_valid(sw_out_valid[g]), .out_ready(1'b1), .out_data(sw_out_data[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] inv_ref(input logic [127:0] d);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++)
      for (int x = 0; x < 256; x++)
        if (SBOX[x] == d[8*i +: 8]) r[8*i +: 8] = 8'(x);
    return r;
  endfunction

  // called and returns at posedge+#1
  task automatic send(input logic [127:0] d, input logic [127:0] e, input bit keep);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
      return;
    end
    in_valid = 1'b1;
    in_data = d;
    exp_q.push_back(e);
    @(posedge clk); #1;
    acc_q.push_back(cyc);
    if (keep && last_acc >= 0) chk("accept_gap", 128'(cyc - last_acc), 128'(NG + 2 + EXTRA));
    last_acc = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && !ov_prev) begin
      if (acc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL latency: out_valid rose with no accept pending");
      end else begin
        mon_acc = acc_q.pop_front();
        chk("latency", 128'(cyc - mon_acc), 128'(LAT));
      end
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data: unexpected output %h", out_data);
      end else chk("out_data", out_data, exp_q.pop_front());
    end
    ov_prev = out_valid;
  end

  initial begin
    logic [127:0] d, e;
    int n, c0;
    int sw_lat [4];
    logic [127:0] sw_got [4];
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_data", out_data, 128'h0);
    rst = 1'b0;
    // LANES sweep on 1, 2, 8, 16
    for (int k = 0; k < 4; k++) sw_lat[k] = -1;
    sw_valid = 1'b1;
    sw_data = BASIC_IN;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    c0 = cyc;
    repeat (25) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++)
        if (sw_out_valid[k] && sw_lat[k] < 0) begin
          sw_lat[k] = cyc - c0;
          sw_got[k] = sw_out_data[k];
        end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sweep_lat%0d", k), 128'(sw_lat[k]), 128'((k == 0 ? 16 : k == 1 ? 8 : k == 2 ? 2 : 1) + EXTRA));
      chk($sformatf("sweep_data%0d", k), sw_got[k], BASIC_EXP);
    end
    // basic and spot vectors
    send(BASIC_IN, BASIC_EXP, 1'b0);
    send(128'h00000000000000000000ed5216007c63, 128'h525252525252525252525348ff520100, 1'b0);
    // exhaustive: word w carries S(16w+i) in byte i
    for (int w = 0; w < 16; w++) begin
      for (int i = 0; i < 16; i++) begin
        d[8*i +: 8] = SBOX[16*w + i];
        e[8*i +: 8] = 8'(16*w + i);
      end
      send(d, e, 1'b0);
    end
    // backpressure in DONE with a competing input word
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    send(128'h0123456789abcdeffedcba9876543210, inv_ref(128'h0123456789abcdeffedcba9876543210), 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    in_data = BASIC_IN;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_data", out_data, inv_ref(128'h0123456789abcdeffedcba9876543210));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    chk("bp_release_out_valid", 128'(out_valid), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_second_accept", 128'(out_valid), 128'(0));
    // reset while grp=2 in BUSY
    send(128'hffeeddccbbaa99887766554433221100, inv_ref(128'hffeeddccbbaa99887766554433221100), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
    chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
    chk("rst_mid_out_data", out_data, 128'h0);
    send(BASIC_IN, BASIC_EXP, 1'b0);
    // back-to-back random words
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    last_acc = -1;
    for (int k = 0; k < 8; k++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(d, inv_ref(d), 1'b1);
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d outputs missing, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
